// File: rtl/cache_pkg.sv
// Shared definitions for the per-set cache controller and cache_line users:
// FSM state encoding, age limits and the way-index width helper.
package cache_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_LOOKUP_ENC    = 3'd1;
  localparam logic [2:0] ST_COMPARE_ENC   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK_ENC = 3'd3;
  localparam logic [2:0] ST_ACCESS_ENC    = 3'd4;
  localparam logic [2:0] ST_RESP_ENC      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_LOOKUP    = ST_LOOKUP_ENC,
    ST_COMPARE   = ST_COMPARE_ENC,
    ST_WRITEBACK = ST_WRITEBACK_ENC,
    ST_ACCESS    = ST_ACCESS_ENC,
    ST_RESP      = ST_RESP_ENC
  } state_e;

  localparam int unsigned DEF_AGE_WIDTH = 2;
  localparam int unsigned DEF_AGE_MAX   = (32'd1 << DEF_AGE_WIDTH) - 32'd1;

  // Saturation value of an age counter of width w
  function automatic int unsigned age_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Width of a way index; at least 1 bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/cache_set_ctrl_victim_select.sv
// victim_select: combinational replacement picker for one set.
// Picks the lowest-index invalid way; when all ways are valid, picks the way
// with the largest age (ties resolve to the lowest index).
// Ports:
//   way_valid_i  valid bit per way
//   way_age_i    packed ages, way i at [i*AGE_WIDTH +: AGE_WIDTH]
//   victim_c     chosen way index (combinational)
module victim_select
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned AGE_WIDTH = DEF_AGE_WIDTH
) (
  input  logic [NUM_WAYS-1:0]           way_valid_i,
  input  logic [NUM_WAYS*AGE_WIDTH-1:0] way_age_i,
  output logic [idx_w(NUM_WAYS)-1:0]    victim_c
);

  localparam int unsigned IDX_W = idx_w(NUM_WAYS);

  logic             found_inv;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_WIDTH-1:0] old_age;

  // Invalid-first scan, then oldest-age scan; strict '>' keeps the lowest index on ties
  always_comb begin
    found_inv = 1'b0;
    inv_idx   = '0;
    old_idx   = '0;
    old_age   = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!way_valid_i[i] && !found_inv) begin
        found_inv = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (way_age_i[i*AGE_WIDTH +: AGE_WIDTH] > old_age) begin
        old_age = way_age_i[i*AGE_WIDTH +: AGE_WIDTH];
        old_idx = IDX_W'(i);
      end
    end
    victim_c = found_inv ? inv_idx : old_idx;
  end

endmodule

// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: per-set controller in front of the NUM_WAYS cache_line
// instances of one set. Takes one CPU byte request at a time, broadcasts the
// latched request to the ways, resolves hit/miss, selects an LRU victim on a
// miss, requests dirty-line writebacks, drives all age pulses and returns one
// response per request.
// Optional build macro: CACHE_STATS_EN adds saturating hit/miss/writeback counters.
// Ports:
//   clk, rst_b                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata     request op, byte address, write byte
//   resp_valid/resp_hit/resp_data    one-cycle response strobe, hit flag, byte
//   way_addr/way_wdata               latched request broadcast to all ways
//   way_try_read/way_try_write       latched op broadcast to all ways
//   way_ready/way_reset_age          one-hot target strobes in ACCESS
//   way_incr_age                     age increment pulses in ACCESS
//   way_hit/valid/dirty/age/data     per-way status from the cache lines
//   mem_wb_valid/mem_wb_way          writeback request and victim index
//   mem_wb_ready                     memory accepts the writeback
//   hit_cnt/miss_cnt/wb_cnt          statistics (CACHE_STATS_EN only)
module cache_set_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDRESS_WORD_SIZE = 32,
  parameter int unsigned NUM_WAYS          = 4,
  parameter int unsigned AGE_WIDTH         = DEF_AGE_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDRESS_WORD_SIZE-1:0]   req_addr,
  input  logic [7:0]                     req_wdata,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [7:0]                     resp_data,
  output logic [ADDRESS_WORD_SIZE-1:0]   way_addr,
  output logic [7:0]                     way_wdata,
  output logic                           way_try_read,
  output logic                           way_try_write,
  output logic [NUM_WAYS-1:0]            way_ready,
  output logic [NUM_WAYS-1:0]            way_reset_age,
  output logic [NUM_WAYS-1:0]            way_incr_age,
  input  logic [NUM_WAYS-1:0]            way_hit,
  input  logic [NUM_WAYS-1:0]            way_valid,
  input  logic [NUM_WAYS-1:0]            way_dirty,
  input  logic [NUM_WAYS*AGE_WIDTH-1:0]  way_age,
  input  logic [NUM_WAYS*8-1:0]          way_data,
  output logic                           mem_wb_valid,
  output logic [idx_w(NUM_WAYS)-1:0]     mem_wb_way,
`ifdef CACHE_STATS_EN
  output logic [15:0]                    hit_cnt,
  output logic [15:0]                    miss_cnt,
  output logic [15:0]                    wb_cnt,
`endif
  input  logic                           mem_wb_ready
);

  localparam int unsigned IDX_W = idx_w(NUM_WAYS);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(age_max(AGE_WIDTH));

  state_e                         state_q, state_d;
  logic [ADDRESS_WORD_SIZE-1:0]   addr_q, addr_d;
  logic [7:0]                     wdata_q, wdata_d;
  logic                           rd_q, rd_d;
  logic                           wr_q, wr_d;
  logic [IDX_W-1:0]               target_q, target_d;
  logic                           hit_q, hit_d;
  logic                           req_ready_q, req_ready_d;
  logic                           resp_valid_q, resp_valid_d;
  logic                           resp_hit_q, resp_hit_d;
  logic                           mem_wb_valid_q, mem_wb_valid_d;
  logic [NUM_WAYS-1:0]            way_ready_q, way_ready_d;
  logic [NUM_WAYS-1:0]            way_reset_age_q, way_reset_age_d;
  logic [NUM_WAYS-1:0]            way_incr_age_q, way_incr_age_d;

  logic [IDX_W-1:0]               victim_c;
  logic [IDX_W-1:0]               hit_idx;
  logic [NUM_WAYS-1:0]            tgt_onehot;

  victim_select #(
    .NUM_WAYS  (NUM_WAYS),
    .AGE_WIDTH (AGE_WIDTH)
  ) u_victim (
    .way_valid_i (way_valid),
    .way_age_i   (way_age),
    .victim_c    (victim_c)
  );

  // Lowest set way_hit bit wins if the ways report more than one hit
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_hit[i]) hit_idx = IDX_W'(i);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    target_d        = target_q;
    hit_d           = hit_q;
    way_incr_age_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = ~req_write;
          wr_d    = req_write;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP:  state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (|way_hit) begin
          target_d = hit_idx;
          hit_d    = 1'b1;
          state_d  = ST_ACCESS;
        end else begin
          target_d = victim_c;
          hit_d    = 1'b0;
          state_d  = (way_valid[victim_c] && way_dirty[victim_c]) ? ST_WRITEBACK : ST_ACCESS;
        end
      end
      ST_WRITEBACK: begin
        if (mem_wb_ready) state_d = ST_ACCESS;
      end
      ST_ACCESS:  state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    tgt_onehot = NUM_WAYS'(1) << target_d;

    req_ready_d     = (state_d == ST_IDLE);
    resp_valid_d    = (state_d == ST_RESP);
    resp_hit_d      = (state_d == ST_RESP) && hit_d;
    mem_wb_valid_d  = (state_d == ST_WRITEBACK);
    way_ready_d     = (state_d == ST_ACCESS) ? tgt_onehot : '0;
    way_reset_age_d = (state_d == ST_ACCESS) ? tgt_onehot : '0;

    // Ages only change in ACCESS, so the values seen the cycle before are current
    if (state_d == ST_ACCESS) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        way_incr_age_d[i] = !tgt_onehot[i] && way_valid[i] &&
                            (way_age[i*AGE_WIDTH +: AGE_WIDTH] != AGE_MAX);
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
      target_q        <= '0;
      hit_q           <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      mem_wb_valid_q  <= 1'b0;
      way_ready_q     <= '0;
      way_reset_age_q <= '0;
      way_incr_age_q  <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      target_q        <= target_d;
      hit_q           <= hit_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      mem_wb_valid_q  <= mem_wb_valid_d;
      way_ready_q     <= way_ready_d;
      way_reset_age_q <= way_reset_age_d;
      way_incr_age_q  <= way_incr_age_d;
    end
  end

  // The target line registers its byte at the end of ACCESS, so RESP muxes it directly
  always_comb begin
    resp_data = 8'h00;
    if (state_q == ST_RESP) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (IDX_W'(i) == target_q) resp_data = way_data[i*8 +: 8];
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign way_addr      = addr_q;
  assign way_wdata     = wdata_q;
  assign way_try_read  = rd_q;
  assign way_try_write = wr_q;
  assign way_ready     = way_ready_q;
  assign way_reset_age = way_reset_age_q;
  assign way_incr_age  = way_incr_age_q;
  assign mem_wb_valid  = mem_wb_valid_q;
  assign mem_wb_way    = target_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == ST_RESP && hit_q && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (state_q == ST_RESP && !hit_q && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
      if (state_q == ST_WRITEBACK && mem_wb_ready && wb_cnt_q != 16'hFFFF)
        wb_cnt_q <= wb_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule
